// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared memory-bus types and constants for the core, LSU and memory responder
package rv32_pkg;

  localparam int MEM_BE_W   = 4;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_WAIT = 2'd1,
    RESP_RESP = 2'd2
  } mem_resp_state_t;

  // Expand byte enables into a full-word bit mask.
  function automatic logic [MEM_DATA_W-1:0] be_mask(input logic [MEM_BE_W-1:0] be);
    logic [MEM_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < MEM_BE_W; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/rv32_mod_sram_1rw.sv
// rtl/rv32_mod_sram_1rw.sv - single-port word RAM, per-byte write enables, registered read
module rv32_mod_sram_1rw
  import rv32_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rd_en,
  input  logic [MEM_BE_W-1:0]            we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [MEM_DATA_W-1:0]          wdata,
  output logic [MEM_DATA_W-1:0]          rdata
);

  logic [MEM_DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [MEM_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < MEM_BE_W; b++) begin
      if (we[b]) begin
        mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (rd_en) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rv32_mod_mem_responder.sv
// rtl/rv32_mod_mem_responder.sv - req/ack/err memory responder with wait states and range errors
// Optional write protection of the low PROTECT_WORDS words: define RV32_MEM_RESP_WR_PROTECT_EN.
module rv32_mod_mem_responder
  import rv32_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          DEPTH_WORDS   = 1024,
  parameter int          WAIT_STATES   = 0,
  parameter int          PROTECT_WORDS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data_o,
  output logic [31:0] data_data_i,
  output logic        data_ack,
  output logic        data_err
);

  localparam int IW = $clog2(DEPTH_WORDS);

  mem_resp_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [3:0]      be_q, be_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            derr_q, derr_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  logic [32:0]     off_w;
  logic [IW-1:0]   idx_w;
  logic            range_err;
  logic            prot_hit;
  logic            dec_err;

  logic            rd_en;
  logic            wr_en;
  logic [IW-1:0]   sram_addr;
  logic [3:0]      sram_we;
  logic [31:0]     sram_rdata;

  // 33-bit offset: bit 32 flags addresses below BASE_ADDR, upper bits flag the top end.
  assign off_w     = {1'b0, data_addr} - {1'b0, BASE_ADDR};
  assign idx_w     = off_w[IW+1:2];
  assign range_err = off_w[32] | ((off_w[31:0] >> (IW + 2)) != 32'd0) | (off_w[1:0] != 2'b00);

`ifdef RV32_MEM_RESP_WR_PROTECT_EN
  assign prot_hit = data_wr && (32'(idx_w) < 32'(PROTECT_WORDS));
`else
  assign prot_hit = (PROTECT_WORDS < 0);
`endif

  assign dec_err = range_err | prot_hit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    be_d      = be_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    derr_d    = derr_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    sram_addr = idx_q;
    case (state_q)
      RESP_IDLE: begin
        if (data_req) begin
          wr_d      = data_wr;
          be_d      = data_be;
          idx_d     = idx_w;
          wdata_d   = data_data_o;
          derr_d    = dec_err;
          sram_addr = idx_w;
          if (WAIT_STATES > 0) begin
            state_d = RESP_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = RESP_RESP;
            ack_d   = !dec_err;
            err_d   = dec_err;
            rd_en   = !data_wr && !dec_err;
          end
        end
      end
      RESP_WAIT: begin
        if (!data_req) begin
          state_d = RESP_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP_RESP;
          ack_d   = !derr_q;
          err_d   = derr_q;
          rd_en   = !wr_q && !derr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP_RESP: begin
        state_d = RESP_IDLE;
        wr_en   = wr_q && !derr_q;
      end
      default: state_d = RESP_IDLE;
    endcase
  end

  // A reset landing on the RESP edge drops the transfer, so the commit is gated too.
  assign sram_we = (wr_en && reset) ? be_q : 4'b0000;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RESP_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      derr_q  <= derr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  rv32_mod_sram_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .rd_en (rd_en && reset),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  assign data_ack    = ack_q;
  assign data_err    = err_q;
  assign data_data_i = (ack_q && !wr_q) ? (sram_rdata & be_mask(be_q)) : 32'd0;

endmodule

// File: tb/tb_rv32_mod_mem_responder.sv
// tb/tb_rv32_mod_mem_responder.sv - directed bench: zero-wait instance A and three-wait instance B
module tb_rv32_mod_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic        wr;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic [31:0] a_rd, b_rd;
  logic        a_ack, a_err, b_ack, b_err;
  logic        sel;
  logic        o_ack, o_err;
  logic [31:0] o_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign o_ack = sel ? b_ack : a_ack;
  assign o_err = sel ? b_err : a_err;
  assign o_rd  = sel ? b_rd  : a_rd;

  rv32_mod_mem_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_STATES(0), .PROTECT_WORDS(4)
  ) dut_a (
    .clk(clk), .reset(reset), .data_req(req_a), .data_wr(wr), .data_be(be),
    .data_addr(addr), .data_data_o(wdata), .data_data_i(a_rd),
    .data_ack(a_ack), .data_err(a_err)
  );

  rv32_mod_mem_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_STATES(3), .PROTECT_WORDS(0)
  ) dut_b (
    .clk(clk), .reset(reset), .data_req(req_b), .data_wr(wr), .data_be(be),
    .data_addr(addr), .data_data_o(wdata), .data_data_i(b_rd),
    .data_ack(b_ack), .data_err(b_err)
  );

  // Issue one request on the selected instance; lat counts cycles from request to response.
  task automatic xfer(input logic inst, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic got_ack, output logic got_err,
                      output logic [31:0] got_rd, output int lat);
    @(negedge clk);
    sel = inst; wr = w; be = b; addr = a; wdata = d;
    if (inst) req_b = 1'b1; else req_a = 1'b1;
    got_ack = 1'b0; got_err = 1'b0; got_rd = '0; lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (o_ack || o_err) begin
        got_ack = o_ack; got_err = o_err; got_rd = o_rd; lat = i;
        break;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0; sel = 1'b0;
    wr = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ack, a_err, b_ack, b_err} !== 4'b0000 || a_rd !== 32'd0 || b_rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack/err=%b a_rd=%h b_rd=%h, want 0000 0 0",
               {a_ack, a_err, b_ack, b_err}, a_rd, b_rd);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_ack, a_err, b_ack, b_err} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: ack/err=%b, want 0000", {a_ack, a_err, b_ack, b_err});
    end
  endtask

  task automatic test_basic();
    logic k, e; logic [31:0] r; int l;
    xfer(1'b0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, k, e, r, l);
    checks++;
    if (k !== 1'b1 || e !== 1'b0 || l != 1) begin
      errors++;
      $display("FAIL basic_write: ack=%b err=%b lat=%0d, want ack=1 err=0 lat=1", k, e, l);
    end
    @(negedge clk);
    checks++;
    if (a_ack !== 1'b0 || a_rd !== 32'd0) begin
      errors++;
      $display("FAIL ack_pulse_width: ack=%b rd=%h, want ack=0 rd=0", a_ack, a_rd);
    end
    xfer(1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || e !== 1'b0 || l != 1 || r !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_read: ack=%b err=%b lat=%0d rd=%h, want 1 0 1 deadbeef", k, e, l, r);
    end
    @(negedge clk);
    checks++;
    if (a_rd !== 32'd0) begin
      errors++;
      $display("FAIL rdata_idle_zero: rd=%h, want 0", a_rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic k, e; logic [31:0] r; int l;
    xfer(1'b0, 1'b1, 4'hF, BASE + 32'h20, 32'h1122_3344, k, e, r, l);
    xfer(1'b0, 1'b1, 4'h8, BASE + 32'h20, 32'hAA00_0000, k, e, r, l);
    xfer(1'b0, 1'b0, 4'hF, BASE + 32'h20, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || r !== 32'hAA22_3344) begin
      errors++;
      $display("FAIL lane_merge: ack=%b rd=%h, want ack=1 rd=aa223344", k, r);
    end
    xfer(1'b0, 1'b0, 4'h3, BASE + 32'h20, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || r !== 32'h0000_3344) begin
      errors++;
      $display("FAIL lane_read_mask: ack=%b rd=%h, want ack=1 rd=00003344", k, r);
    end
    xfer(1'b0, 1'b1, 4'h0, BASE + 32'h20, 32'hFFFF_FFFF, k, e, r, l);
    checks++;
    if (k !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL be_zero_ack: ack=%b err=%b, want ack=1 err=0", k, e);
    end
    xfer(1'b0, 1'b0, 4'hF, BASE + 32'h20, 32'd0, k, e, r, l);
    checks++;
    if (r !== 32'hAA22_3344) begin
      errors++;
      $display("FAIL be_zero_unchanged: rd=%h, want aa223344", r);
    end
  endtask

  task automatic test_errors();
    logic k, e; logic [31:0] r; int l;
    logic [31:0] bad [4];
    bad[0] = BASE + 32'h2; bad[1] = BASE + 32'h22; bad[2] = BASE + 32'h400; bad[3] = BASE - 32'h4;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 1'b0, 4'hF, bad[i], 32'd0, k, e, r, l);
      checks++;
      if (k !== 1'b0 || e !== 1'b1 || r !== 32'd0 || l != 1) begin
        errors++;
        $display("FAIL err_read[%0d]: addr=%h ack=%b err=%b rd=%h lat=%0d, want 0 1 0 1",
                 i, bad[i], k, e, r, l);
      end
      xfer(1'b0, 1'b1, 4'hF, bad[i], 32'hFFFF_FFFF, k, e, r, l);
      checks++;
      if (k !== 1'b0 || e !== 1'b1) begin
        errors++;
        $display("FAIL err_write[%0d]: addr=%h ack=%b err=%b, want ack=0 err=1", i, bad[i], k, e);
      end
    end
    xfer(1'b0, 1'b0, 4'hF, BASE + 32'h20, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || r !== 32'hAA22_3344) begin
      errors++;
      $display("FAIL err_no_side_effect_20: ack=%b rd=%h, want 1 aa223344", k, r);
    end
    xfer(1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || r !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL err_no_side_effect_10: ack=%b rd=%h, want 1 deadbeef", k, r);
    end
  endtask

  task automatic test_wait_states();
    logic k, e; logic [31:0] r; int l;
    int first, second, pulses;
    xfer(1'b1, 1'b1, 4'hF, BASE, 32'h1234_5678, k, e, r, l);
    checks++;
    if (k !== 1'b1 || l != 4) begin
      errors++;
      $display("FAIL wait_latency: ack=%b lat=%0d, want ack=1 lat=4", k, l);
    end
    // Request held high through two responses.
    @(negedge clk);
    sel = 1'b1; wr = 1'b1; be = 4'hF; addr = BASE + 32'h4; wdata = 32'hCAFE_F00D; req_b = 1'b1;
    first = -1; second = -1;
    for (int i = 1; i <= 40 && second < 0; i++) begin
      @(negedge clk);
      if (b_ack) begin
        if (first < 0) first = i; else second = i;
      end
    end
    req_b = 1'b0;
    checks++;
    if (first != 4 || second != 9) begin
      errors++;
      $display("FAIL back_to_back: acks at %0d,%0d, want 4,9", first, second);
    end
    // Abort: request dropped two cycles after it rose.
    @(negedge clk);
    wr = 1'b1; be = 4'hF; addr = BASE; wdata = 32'h5555_5555; req_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_b = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (b_ack || b_err) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_no_resp: pulses=%0d, want 0", pulses);
    end
    xfer(1'b1, 1'b0, 4'hF, BASE, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || l != 4 || r !== 32'h1234_5678) begin
      errors++;
      $display("FAIL abort_no_write: ack=%b lat=%0d rd=%h, want 1 4 12345678", k, l, r);
    end
    xfer(1'b1, 1'b0, 4'hF, BASE + 32'h4, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || r !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL held_req_write: ack=%b rd=%h, want 1 cafef00d", k, r);
    end
  endtask

  task automatic test_reset_in_wait();
    logic k, e; logic [31:0] r; int l;
    int bad_cycles;
    @(negedge clk);
    sel = 1'b1; wr = 1'b1; be = 4'hF; addr = BASE; wdata = 32'h0BAD_F00D; req_b = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_b = 1'b0;
    bad_cycles = 0;
    repeat (4) begin
      @(negedge clk);
      if (b_ack || b_err || b_rd !== 32'd0 || a_ack || a_err || a_rd !== 32'd0) bad_cycles++;
    end
    checks++;
    if (bad_cycles != 0) begin
      errors++;
      $display("FAIL reset_in_wait_outputs: nonzero cycles=%0d, want 0", bad_cycles);
    end
    reset = 1'b1;
    xfer(1'b1, 1'b0, 4'hF, BASE, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || e !== 1'b0 || l != 4 || r !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset_dropped_write: ack=%b err=%b lat=%0d rd=%h, want 1 0 4 12345678",
               k, e, l, r);
    end
  endtask

  task automatic test_protect();
    logic k, e; logic [31:0] r; int l;
    xfer(1'b0, 1'b1, 4'hF, BASE + 32'hC, 32'h3333_3333, k, e, r, l);
`ifdef RV32_MEM_RESP_WR_PROTECT_EN
    checks++;
    if (k !== 1'b0 || e !== 1'b1) begin
      errors++;
      $display("FAIL protect_err: ack=%b err=%b, want ack=0 err=1", k, e);
    end
    xfer(1'b0, 1'b0, 4'hF, BASE + 32'hC, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || r === 32'h3333_3333) begin
      errors++;
      $display("FAIL protect_unchanged: ack=%b rd=%h, want ack=1 rd!=33333333", k, r);
    end
`else
    checks++;
    if (k !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL noprotect_ack: ack=%b err=%b, want ack=1 err=0", k, e);
    end
    xfer(1'b0, 1'b0, 4'hF, BASE + 32'hC, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || r !== 32'h3333_3333) begin
      errors++;
      $display("FAIL noprotect_write: ack=%b rd=%h, want 1 33333333", k, r);
    end
`endif
    xfer(1'b0, 1'b1, 4'hF, BASE + 32'h10, 32'h4444_4444, k, e, r, l);
    checks++;
    if (k !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL idx4_write_ack: ack=%b err=%b, want ack=1 err=0", k, e);
    end
    xfer(1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'd0, k, e, r, l);
    checks++;
    if (k !== 1'b1 || r !== 32'h4444_4444) begin
      errors++;
      $display("FAIL idx4_readback: ack=%b rd=%h, want 1 44444444", k, r);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_wait_states();
    test_reset_in_wait();
    test_protect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
